// File: rtl/serial_link_sync_ctrl_pkg.sv
// serial_link_sync_ctrl_pkg: shared state encoding and symbol defaults for the serial link sync controller
package serial_link_sync_ctrl_pkg;
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        UPSET  = 2'd3
    } sls_state_e;
    localparam logic [7:0] COMMA_DEF      = 8'hBC;
    localparam logic [7:0] IDLE_DEF       = 8'h7C;
    localparam int         COMMA_CNT_DEF  = 4;
    localparam int         WDOG_BYTES_DEF = 16;
endpackage

// File: rtl/serial_link_sync_ctrl_framer.sv
// sls_framer: serial shift register, byte framing counter and symbol compare
module sls_framer
    import serial_link_sync_ctrl_pkg::*;
#(
    parameter logic [7:0] COMMA    = COMMA_DEF,
    parameter logic [7:0] IDLE_SYM = IDLE_DEF
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       align,
    input  logic       clr,
    output logic [7:0] sr_next,
    output logic       boundary,
    output logic       is_comma,
    output logic       is_idle
);
    // only seven history bits are needed: the eighth comes from data_in
    logic [6:0] sr;
    logic [2:0] bit_cnt;
    assign sr_next  = {sr, data_in};
    assign boundary = bit_cnt == 3'd7;
    assign is_comma = sr_next == COMMA;
    assign is_idle  = sr_next == IDLE_SYM;
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr      <= sr_next[6:0];
            bit_cnt <= (align || clr) ? 3'd0 : bit_cnt + 3'd1;
        end
    end
endmodule

// File: rtl/serial_link_sync_ctrl.sv
// serial_link_sync_ctrl: comma hunt, link activation and byte framing for the serial receive path.
// Define SLS_LOCK_LOSS_EN to add the ACTIVE data-byte watchdog (WDOG_BYTES).
module serial_link_sync_ctrl
    import serial_link_sync_ctrl_pkg::*;
#(
    parameter logic [7:0] COMMA     = COMMA_DEF,
    parameter logic [7:0] IDLE_SYM  = IDLE_DEF,
    parameter int         COMMA_CNT = COMMA_CNT_DEF
`ifdef SLS_LOCK_LOSS_EN
    ,
    parameter int         WDOG_BYTES = WDOG_BYTES_DEF
`endif
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       enable,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       byte_valid,
    output logic       active,
    output logic       IDLEOut,
    output logic [1:0] lock_state
);
    sls_state_e state, state_d;
    logic [3:0] comma_cnt, comma_d;
    logic [7:0] sr_next, data_d;
    logic       boundary, is_comma, is_idle, align;
    logic       active_d, idle_d, bv_d;
`ifdef SLS_LOCK_LOSS_EN
    logic [7:0] wd_cnt, wd_d;
`endif
    sls_framer #(.COMMA(COMMA), .IDLE_SYM(IDLE_SYM)) u_framer (
        .clk_32f (clk_32f),
        .reset   (reset),
        .data_in (data_in),
        .align   (align),
        .clr     (!enable),
        .sr_next (sr_next),
        .boundary(boundary),
        .is_comma(is_comma),
        .is_idle (is_idle)
    );
    assign lock_state = state;
    always_comb begin
        state_d  = state;
        comma_d  = comma_cnt;
        active_d = active;
        idle_d   = IDLEOut;
        data_d   = data_out;
        bv_d     = 1'b0;
        align    = 1'b0;
`ifdef SLS_LOCK_LOSS_EN
        wd_d     = wd_cnt;
`endif
        if (!enable) begin
            state_d  = HUNT;
            comma_d  = '0;
            active_d = 1'b0;
            idle_d   = 1'b0;
`ifdef SLS_LOCK_LOSS_EN
            wd_d     = '0;
`endif
        end else begin
            case (state)
                HUNT: if (is_comma) begin
                    align    = 1'b1;
                    comma_d  = 4'd1;
                    state_d  = (COMMA_CNT == 1) ? ACTIVE : SYNC;
                    active_d = COMMA_CNT == 1;
                end
                SYNC: if (boundary) begin
                    comma_d  = is_comma ? comma_cnt + 4'd1 : 4'd0;
                    state_d  = !is_comma ? HUNT : (comma_d == 4'(COMMA_CNT)) ? ACTIVE : SYNC;
                    active_d = is_comma && comma_d == 4'(COMMA_CNT);
                end
                ACTIVE: if (boundary) begin
`ifdef SLS_LOCK_LOSS_EN
                    wd_d = '0;
`endif
                    if (is_idle) begin
                        idle_d = 1'b1;
                    end else if (!is_comma) begin
                        data_d = sr_next;
                        bv_d   = 1'b1;
                        idle_d = 1'b0;
`ifdef SLS_LOCK_LOSS_EN
                        // the tripping byte is still delivered; only the link drops
                        wd_d = wd_cnt + 8'd1;
                        if (wd_d == 8'(WDOG_BYTES)) begin
                            state_d  = HUNT;
                            active_d = 1'b0;
                            comma_d  = '0;
                            wd_d     = '0;
                        end
`endif
                    end
                end
                default: begin
                    state_d  = HUNT;
                    comma_d  = '0;
                    active_d = 1'b0;
                    idle_d   = 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state      <= HUNT;
            comma_cnt  <= '0;
            active     <= 1'b0;
            IDLEOut    <= 1'b0;
            data_out   <= '0;
            byte_valid <= 1'b0;
`ifdef SLS_LOCK_LOSS_EN
            wd_cnt     <= '0;
`endif
        end else begin
            state      <= state_d;
            comma_cnt  <= comma_d;
            active     <= active_d;
            IDLEOut    <= idle_d;
            data_out   <= data_d;
            byte_valid <= bv_d;
`ifdef SLS_LOCK_LOSS_EN
            wd_cnt     <= wd_d;
`endif
        end
    end
endmodule

// File: tb/tb_serial_link_sync_ctrl.sv
// tb_serial_link_sync_ctrl: directed bench with a bit-level link model checked every cycle
module tb_serial_link_sync_ctrl;
    localparam logic [7:0] C_COMMA = 8'hBC;
    localparam logic [7:0] C_IDLE  = 8'h7C;
    localparam int         NCOMMA  = 4;
    localparam int         WDOG    = 16;
    logic       clk_32f = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       byte_valid, active, IDLEOut;
    logic [1:0] lock_state;
    int total = 0;
    int bad = 0;
    int strobes = 0;
    logic [7:0] w, m_data;
    logic       m_bv, m_act, m_idle;
    int mode, pos, commas, wd;
    serial_link_sync_ctrl dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .enable    (enable),
        .data_in   (data_in),
        .data_out  (data_out),
        .byte_valid(byte_valid),
        .active    (active),
        .IDLEOut   (IDLEOut),
        .lock_state(lock_state)
    );
    always #5 clk_32f = ~clk_32f;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    task automatic model_reset();
        w = '0; m_data = '0; m_bv = 1'b0; m_act = 1'b0; m_idle = 1'b0;
        mode = 0; pos = 0; commas = 0; wd = 0;
    endtask
    // mode: 0 hunting, 1 counting commas, 2 link up; pos = bits since last byte boundary
    task automatic model_step(input logic en, input logic b);
        w = {w[6:0], b};
        m_bv = 1'b0;
        if (!en) begin
            mode = 0; pos = 0; commas = 0; wd = 0; m_act = 1'b0; m_idle = 1'b0;
        end else if (mode == 0) begin
            if (w == C_COMMA) begin
                pos = 0; commas = 1;
                mode = (NCOMMA == 1) ? 2 : 1;
                m_act = (NCOMMA == 1);
            end
        end else begin
            pos++;
            if (pos == 8) begin
                pos = 0;
                if (mode == 1) begin
                    if (w == C_COMMA) begin
                        commas++;
                        if (commas == NCOMMA) begin mode = 2; m_act = 1'b1; end
                    end else begin
                        commas = 0; mode = 0;
                    end
                end else if (w == C_COMMA) begin
                    wd = 0;
                end else if (w == C_IDLE) begin
                    wd = 0; m_idle = 1'b1;
                end else begin
                    m_data = w; m_bv = 1'b1; m_idle = 1'b0;
`ifdef SLS_LOCK_LOSS_EN
                    wd++;
                    if (wd == WDOG) begin mode = 0; m_act = 1'b0; wd = 0; commas = 0; end
`endif
                end
            end
        end
    endtask
    task automatic tick(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        model_step(enable, b);
        if (byte_valid) strobes++;
        chk("cycle", {data_out, byte_valid, active, IDLEOut, lock_state},
            {m_data, m_bv, m_act, m_idle, 2'(mode)});
    endtask
    task automatic send(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) tick(v[i]);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        model_reset();
        repeat (3) @(posedge clk_32f);
        #1;
        chk("reset_state", {data_out, byte_valid, active, IDLEOut, lock_state}, 32'd0);
        reset = 1'b1;
        enable = 1'b1;
        repeat (64) tick(1'b0);
        chk("idle_hunt", lock_state, 32'd0);
        chk("idle_outputs", {data_out, byte_valid, active, IDLEOut}, 32'd0);
        tick(1'b1); tick(1'b0); tick(1'b1);
        send(C_COMMA);
        chk("sync_after_first", lock_state, 32'd1);
        send(C_COMMA); send(C_COMMA);
        chk("inactive_after_3", active, 32'd0);
        send(C_COMMA);
        chk("active_after_4", active, 32'd1);
        chk("lock_active", lock_state, 32'd2);
        send(8'h5A);
        chk("strobe_5a", byte_valid, 32'd1);
        chk("data_5a", data_out, 32'h5A);
        send(C_COMMA);
        chk("comma_no_strobe", byte_valid, 32'd0);
        chk("comma_data_held", data_out, 32'h5A);
        send(C_IDLE);
        chk("idle_flag", IDLEOut, 32'd1);
        chk("idle_no_strobe", byte_valid, 32'd0);
        send(8'h33);
        chk("idle_cleared", IDLEOut, 32'd0);
        chk("data_33", data_out, 32'h33);
        tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b1);
        enable = 1'b0;
        tick(1'b0);
        chk("disable_inactive", active, 32'd0);
        chk("disable_hunt", lock_state, 32'd0);
        chk("disable_data_held", data_out, 32'h33);
        enable = 1'b1;
        send(C_COMMA); send(C_COMMA); send(C_COMMA);
        chk("reenable_3", active, 32'd0);
        send(C_COMMA);
        chk("reenable_4", active, 32'd1);
        tick(1'b1); tick(1'b0); tick(1'b1);
        #3 reset = 1'b0;
        #1;
        model_reset();
        chk("async_reset", {data_out, byte_valid, active, IDLEOut, lock_state}, 32'd0);
        #2 reset = 1'b1;
        send(C_COMMA); send(C_COMMA); send(C_COMMA);
        chk("pre_a5_sync", lock_state, 32'd1);
        send(8'hA5);
        chk("a5_hunt", lock_state, 32'd0);
        chk("a5_inactive", active, 32'd0);
        repeat (8) tick(1'b0);
        repeat (NCOMMA) send(C_COMMA);
        chk("relock", active, 32'd1);
        strobes = 0;
`ifdef SLS_LOCK_LOSS_EN
        repeat (WDOG) send(8'h11);
        chk("wdog_strobes", strobes, WDOG);
        chk("wdog_trip", active, 32'd0);
        chk("wdog_hunt", lock_state, 32'd0);
        repeat (8) tick(1'b0);
        repeat (NCOMMA) send(C_COMMA);
        repeat (WDOG - 2) send(8'h11);
        send(C_COMMA);
        repeat (WDOG - 1) send(8'h11);
        chk("wdog_reset_by_comma", active, 32'd1);
        send(8'h11);
        chk("wdog_trip_again", active, 32'd0);
`else
        repeat (20) send(8'h11);
        chk("sticky_strobes", strobes, 32'd20);
        chk("sticky_active", active, 32'd1);
        chk("sticky_data", data_out, 32'h11);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
